// File: rtl/mem_lsu.sv
// Load/store initiator: byte/half/word loads and stores turned into 32-bit word accesses; sub-word stores use read-modify-write.
// Latency: load and word store 2 edges from accept to done; sub-word store 3 edges; a flagged misaligned access 1 edge.
// Backpressure: ready only in IDLE, busy stalls the pipeline; one request in flight; a new req may be taken in the done cycle.
//
// Ports:
//   clk, clrn                     clock (posedge) and asynchronous active-low reset
//   req, wr, size, sign_ext       request sampled when ready=1; size 00 byte, 01 half, 10/11 word
//   addr, wdata                   byte address, right-aligned store data
//   ready, busy, done, rdata, err handshake, completion pulse, load result (held), misalign flag
//   mem_we, mem_addr, mem_datain  word memory write strobe, word address, write data
//   mem_dataout                   combinational memory read data
//
// Optional feature: define MISALIGN_CHK_EN to flag misaligned half/word accesses with err instead of
// silently aligning them down.

module mem_lsu #(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_datain,
    input  logic [31:0]       mem_dataout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              wr_q;
    logic              sext_q;
    logic [31:0]       merge_q;

    // Physical bit position of a byte lane. Big-endian puts lane 0 in the top byte,
    // which is the same as inverting the lane index.
    function automatic logic [4:0] lane_pos(input logic [1:0] k);
        logic [1:0] p;
        p = (BIG_ENDIAN != 0) ? ~k : k;
        return {p, 3'b000};
    endfunction

    function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] k);
        return w[lane_pos(k) +: 8];
    endfunction

    function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[lane_pos(k) +: 8] = b;
        return r;
    endfunction

    // Load result from the fetched word: pick lane(s) from the latched address, then extend.
    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                            input logic [1:0] a, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [1:0]  k;
        k = {a[1], 1'b0};
        b = get_lane(d, a);
        // Lower-numbered lane is the low half in little-endian and the high half in big-endian.
        h = (BIG_ENDIAN != 0) ? {get_lane(d, k), get_lane(d, k | 2'b01)}
                              : {get_lane(d, k | 2'b01), get_lane(d, k)};
        case (sz)
            2'b00:   return {{24{sx & b[7]}}, b};
            2'b01:   return {{16{sx & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    // New word for a sub-word store: the read word with the addressed lane(s) replaced.
    function automatic logic [31:0] merge(input logic [31:0] d, input logic [1:0] sz,
                                          input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] r;
        logic [1:0]  k;
        k = {a[1], 1'b0};
        r = d;
        if (sz == 2'b00) begin
            r = set_lane(r, a, wd[7:0]);
        end else if (BIG_ENDIAN != 0) begin
            r = set_lane(r, k, wd[15:8]);
            r = set_lane(r, k | 2'b01, wd[7:0]);
        end else begin
            r = set_lane(r, k, wd[7:0]);
            r = set_lane(r, k | 2'b01, wd[15:8]);
        end
        return r;
    endfunction

    logic misalign;
`ifdef MISALIGN_CHK_EN
    always_comb begin
        misalign = 1'b0;
        if (size == 2'b01)
            misalign = addr[0];
        else if (size[1])
            misalign = (addr[1:0] != 2'b00);
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            wr_q    <= 1'b0;
            sext_q  <= 1'b0;
            merge_q <= 32'd0;
        end else begin
            // done/err are single-cycle pulses unless re-armed below.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        size_q  <= size;
                        wr_q    <= wr;
                        sext_q  <= sign_ext;
                        if (misalign) begin
                            // Rejected without touching memory; rdata keeps its old value.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (!wr) begin
                            state <= S_RD;
                        end else if (size[1]) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end
                S_RD: begin
                    rdata <= extract(mem_dataout, size_q, addr_q[1:0], sext_q);
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_WR: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_RMW_RD: begin
                    merge_q <= merge(mem_dataout, size_q, addr_q[1:0], wdata_q);
                    state   <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // wr_q is kept for visibility of the in-flight request; the state already encodes direction.
    logic unused_wr;
    assign unused_wr = wr_q;

    assign ready    = (state == S_IDLE);
    assign busy     = ~ready;
    // Write strobe decoded from state alone so reset drops it immediately.
    assign mem_we   = (state == S_WR) || (state == S_RMW_WR);
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        mem_datain = 32'd0;
        if (state == S_WR)
            mem_datain = wdata_q;
        else if (state == S_RMW_WR)
            mem_datain = merge_q;
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk;
    logic        clrn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    logic [31:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        we;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] last_rdata;

    mem_lsu #(.ADDR_W(32), .BIG_ENDIAN(0)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req        (req),
        .wr         (wr),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on posedge.
    assign mem_dataout = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr[7:2]] <= mem_datain;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with ready=1. Returns at the negedge where done is seen,
    // so the next call issues a back-to-back request.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] load_val, input int lat, input logic exp_err);
        exp_t e;
        exp_t got_e;
        int   n;
        int   busy_n;
        logic saw_we;
        logic got;
        e.err   = exp_err;
        e.lat   = lat;
        e.we    = w & ~exp_err;
        e.rdata = (w || exp_err) ? last_rdata : load_val;
        last_rdata = e.rdata;
        sbq.push_back(e);

        req = 1'b1; wr = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;

        n = 0; busy_n = 0; saw_we = 1'b0; got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (mem_we) saw_we = 1'b1;
            if (busy) busy_n++;
            if (done) begin
                got = 1'b1;
                n = i;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (sbq.size() > 0) begin
            got_e = sbq.pop_front();
            if (got) begin
                chk({tag, "_latency"}, n, got_e.lat);
                chk({tag, "_rdata"}, rdata, got_e.rdata);
                chk({tag, "_err"}, {31'd0, err}, {31'd0, got_e.err});
                chk({tag, "_mem_we_seen"}, {31'd0, saw_we}, {31'd0, got_e.we});
                chk({tag, "_busy_cycles"}, busy_n, got_e.lat - 1);
            end
        end
    endtask

    initial begin
        logic saw_done;
        for (int i = 0; i < 64; i++) mem[i] = (i >= 1 && i <= 8) ? i : 0;
        clrn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        last_rdata = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_datain", mem_datain, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        xact("ld_w_08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h00000002, 2, 1'b0);
`ifdef MISALIGN_CHK_EN
        xact("ld_w_06_mis", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1, 1'b1);
`else
        xact("ld_w_06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h00000001, 2, 1'b0);
`endif
        xact("st_b_05", 1'b1, 2'b00, 1'b0, 32'h05, 32'h000000AB, 32'h0, 3, 1'b0);
        xact("ld_b_05_s", 1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 32'hFFFFFFAB, 2, 1'b0);
        xact("ld_b_05_u", 1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'h000000AB, 2, 1'b0);
        xact("st_h_0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF1234, 32'h0, 3, 1'b0);
        xact("ld_h_0e_u", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'h00001234, 2, 1'b0);
        xact("ld_b_0f_s", 1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, 32'h00000012, 2, 1'b0);
        xact("st_w_18", 1'b1, 2'b10, 1'b0, 32'h18, 32'hDEADBEEF, 32'h0, 2, 1'b0);
        xact("ld_h_1a_s", 1'b0, 2'b01, 1'b1, 32'h1A, 32'h0, 32'hFFFFDEAD, 2, 1'b0);
        xact("ld_sz3_18", 1'b0, 2'b11, 1'b0, 32'h18, 32'h0, 32'hDEADBEEF, 2, 1'b0);
        xact("ld_h_18_s", 1'b0, 2'b01, 1'b1, 32'h18, 32'h0, 32'hFFFFBEEF, 2, 1'b0);

        @(negedge clk);
        chk("mem_word1", mem[1], 32'h0000AB01);
        chk("mem_word2", mem[2], 32'h00000002);
        chk("mem_word3", mem[3], 32'h12340003);
        chk("mem_word6", mem[6], 32'hDEADBEEF);
        chk("sb_empty", sbq.size(), 32'd0);

        // Byte store @0x10 aborted by reset while in the read half of read-modify-write.
        req = 1'b1; wr = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h000000CD;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_we) saw_done = 1'b1;
        end
        chk("abort_no_done_or_we", {31'd0, saw_done}, 32'd0);
        chk("abort_word4", mem[4], 32'h00000004);
        chk("abort_ready_after", {31'd0, ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
